// File: rtl/nv_nvdla_rubik_wcmd_exec.sv
// RUBIK write-command executor: pops write commands, streams buffer entries out as
// one DMA write header plus data beats, and returns buffer credits / layer-done pulses.
module nv_nvdla_rubik_wcmd_exec #(
    parameter int DW      = 256,
    parameter int MAX_ACK = 7
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          cmd_pvld,
    output logic          cmd_prdy,
    input  logic [10:0]   cmd_pd,
    input  logic [63:0]   reg2dp_dst_base_addr,
    output logic          buf_rd_en,
    output logic [4:0]    buf_rd_addr,
    input  logic [DW-1:0] buf_rd_data,
    output logic          dma_wr_req_pvld,
    input  logic          dma_wr_req_prdy,
    output logic [DW:0]   dma_wr_req_pd,
    input  logic          dma_wr_rsp_complete,
    output logic          buf_rls_vld,
    output logic [5:0]    buf_rls_cnt,
    output logic          layer_done
);

    localparam int AW = $clog2(MAX_ACK + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        state;
    logic [4:0]    size_m1;
    logic          last;
    logic [5:0]    rd_left;
    logic [5:0]    beat_left;
    logic [63:0]   addr_cnt;
    logic [AW-1:0] ack_cnt;
    logic          inflight;
    logic [1:0]    skid_cnt;
    logic          skid_rp;
    logic          skid_wp;
    logic [DW-1:0] skid_mem [2];

    logic [5:0]    beats;
    logic          cmd_acc;
    logic          hdr_acc;
    logic          data_vld;
    logic          data_acc;
    logic          last_beat;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    assign beats    = {1'b0, size_m1} + 6'd1;
    assign cmd_prdy = nvdla_core_rstn && (state == IDLE) && (ack_cnt < AW'(MAX_ACK));
    assign cmd_acc  = cmd_pvld && cmd_prdy;
    assign hdr_acc  = (state == HDR) && dma_wr_req_prdy;

    // A read return may be forwarded straight to the DMA port when the skid is empty,
    // which gives the one-beat-per-cycle throughput with only two storage slots.
    assign data_vld  = (skid_cnt != 2'd0) || inflight;
    assign head      = (skid_cnt != 2'd0) ? skid_mem[skid_rp] : buf_rd_data;
    assign data_acc  = (state == DATA) && data_vld && dma_wr_req_prdy;
    assign pop       = (skid_cnt != 2'd0) && data_acc;
    assign push      = inflight && !((skid_cnt == 2'd0) && data_acc);
    assign last_beat = data_acc && (beat_left == 6'd1);

    assign buf_rd_en = (state != IDLE) && (rd_left != 6'd0) &&
                       (({1'b0, skid_cnt} + {2'b00, inflight}) < 3'd2);

    assign dma_wr_req_pvld = (state == HDR) || ((state == DATA) && data_vld);

    always_comb begin
        dma_wr_req_pd = '0;
        if (state == DATA) begin
            dma_wr_req_pd = {1'b1, head};
        end else begin
            dma_wr_req_pd[63:0]  = addr_cnt;
            dma_wr_req_pd[68:64] = size_m1;
            dma_wr_req_pd[69]    = last;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state       <= IDLE;
            size_m1     <= '0;
            last        <= 1'b0;
            rd_left     <= '0;
            beat_left   <= '0;
            buf_rd_addr <= '0;
            addr_cnt    <= reg2dp_dst_base_addr;
            ack_cnt     <= '0;
            inflight    <= 1'b0;
            skid_cnt    <= '0;
            skid_rp     <= 1'b0;
            skid_wp     <= 1'b0;
            buf_rls_vld <= 1'b0;
            buf_rls_cnt <= '0;
            layer_done  <= 1'b0;
        end else begin
            inflight <= buf_rd_en;
            if (buf_rd_en) begin
                buf_rd_addr <= buf_rd_addr + 5'd1;
                rd_left     <= rd_left - 6'd1;
            end

            case (state)
                IDLE: if (cmd_acc) begin
                    size_m1     <= cmd_pd[4:0];
                    buf_rd_addr <= cmd_pd[9:5];
                    last        <= cmd_pd[10];
                    rd_left     <= {1'b0, cmd_pd[4:0]} + 6'd1;
                    beat_left   <= {1'b0, cmd_pd[4:0]} + 6'd1;
                    state       <= HDR;
                end
                HDR: if (dma_wr_req_prdy) state <= DATA;
                DATA: begin
                    if (data_acc) beat_left <= beat_left - 6'd1;
                    if (last_beat) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (push) skid_wp <= ~skid_wp;
            if (pop)  skid_rp <= ~skid_rp;
            skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};

            buf_rls_vld <= last_beat;
            if (last_beat) begin
                buf_rls_cnt <= beats;
                addr_cnt    <= last ? reg2dp_dst_base_addr
                                    : addr_cnt + 64'(beats) * 64'(DW / 8);
            end

            case ({hdr_acc && last, dma_wr_rsp_complete})
                2'b10:   ack_cnt <= ack_cnt + AW'(1);
                2'b01:   ack_cnt <= ack_cnt - AW'(1);
                default: ack_cnt <= ack_cnt;
            endcase
            layer_done <= dma_wr_rsp_complete;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by skid_cnt.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) skid_mem[skid_wp] <= buf_rd_data;
    end

    ack_underflow: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        dma_wr_rsp_complete |-> (ack_cnt != '0));

endmodule

// File: tb/tb_nv_nvdla_rubik_wcmd_exec.sv
// Scoreboard bench for nv_nvdla_rubik_wcmd_exec: directed commands, queued expectations,
// negedge monitor for DMA requests, buffer read addresses and credit returns.
module tb_nv_nvdla_rubik_wcmd_exec;
    localparam int DW = 256;
    typedef logic [DW:0] pd_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_pvld;
    logic          cmd_prdy;
    logic [10:0]   cmd_pd;
    logic [63:0]   base_addr;
    logic          buf_rd_en;
    logic [4:0]    buf_rd_addr;
    logic [DW-1:0] buf_rd_data;
    logic          req_pvld;
    logic          req_prdy;
    pd_t           req_pd;
    logic          complete;
    logic          rls_vld;
    logic [5:0]    rls_cnt;
    logic          layer_done;

    always #5 clk = ~clk;

    nv_nvdla_rubik_wcmd_exec #(.DW(DW), .MAX_ACK(7)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .cmd_pvld(cmd_pvld), .cmd_prdy(cmd_prdy), .cmd_pd(cmd_pd),
        .reg2dp_dst_base_addr(base_addr),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .dma_wr_req_pvld(req_pvld), .dma_wr_req_prdy(req_prdy), .dma_wr_req_pd(req_pd),
        .dma_wr_rsp_complete(complete),
        .buf_rls_vld(rls_vld), .buf_rls_cnt(rls_cnt), .layer_done(layer_done)
    );

    logic [DW-1:0] mem [32];
    pd_t           exp_q [$];
    logic [4:0]    ra_q  [$];
    logic [5:0]    rls_q [$];
    int checks = 0, errors = 0, cyc = 0;
    int acc_cyc = 0, hdr_cyc = 0, rls_cyc = 0;
    int rd_issued = 0, data_acc_n = 0, max_occ = 0;
    bit rand_prdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Buffer model: data valid exactly one cycle after the read strobe, zero otherwise.
    initial begin
        logic       e;
        logic [4:0] a;
        buf_rd_data = '0;
        forever begin
            @(posedge clk);
            e = buf_rd_en;
            a = buf_rd_addr;
            #1;
            buf_rd_data = e ? mem[a] : '0;
        end
    end

    initial begin
        req_prdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            req_prdy = rand_prdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor
    initial begin
        pd_t        held, e;
        bit         held_v;
        logic [4:0] ra;
        logic [5:0] rc;
        held_v = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held_v = 0;
                rd_issued = 0;
                data_acc_n = 0;
            end else begin
                if (rd_issued - data_acc_n > max_occ) max_occ = rd_issued - data_acc_n;
                if (held_v) begin
                    checks++;
                    if (!(req_pvld && req_pd === held)) begin
                        errors++;
                        $display("FAIL pd_stable: got vld=%0b pd=%h expected %h", req_pvld, req_pd, held);
                    end
                end
                held_v = req_pvld && !req_prdy;
                held = req_pd;
                if (req_pvld && req_prdy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL dma_req: got unexpected %h expected none", req_pd);
                    end else begin
                        e = exp_q.pop_front();
                        if (req_pd !== e) begin
                            errors++;
                            $display("FAIL dma_req: got %h expected %h", req_pd, e);
                        end
                    end
                    if (req_pd[DW]) data_acc_n++;
                    else hdr_cyc = cyc;
                end
                if (buf_rd_en) begin
                    rd_issued++;
                    if (ra_q.size() == 0) chk("rd_addr_unexpected", 64'(buf_rd_addr), 64'hFFFF);
                    else begin
                        ra = ra_q.pop_front();
                        chk("rd_addr", 64'(buf_rd_addr), 64'(ra));
                    end
                end
                if (rls_vld) begin
                    rls_cyc = cyc;
                    if (rls_q.size() == 0) chk("rls_unexpected", 64'(rls_cnt), 64'hFFFF);
                    else begin
                        rc = rls_q.pop_front();
                        chk("rls_cnt", 64'(rls_cnt), 64'(rc));
                    end
                end
            end
        end
    end

    task automatic send(input int beats, input int base, input bit last, input logic [63:0] addr);
        pd_t        h;
        logic [4:0] ra;
        bit         done;
        h = '0;
        h[63:0]  = addr;
        h[68:64] = 5'(beats - 1);
        h[69]    = last;
        exp_q.push_back(h);
        for (int k = 0; k < beats; k++) begin
            ra = 5'((base + k) % 32);
            ra_q.push_back(ra);
            exp_q.push_back({1'b1, mem[ra]});
        end
        rls_q.push_back(6'(beats));
        cmd_pd = {last, 5'(base), 5'(beats - 1)};
        cmd_pvld = 1'b1;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (cmd_prdy) begin
                acc_cyc = cyc;
                done = 1;
            end
        end
        if (!done) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        cmd_pvld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() + ra_q.size() + rls_q.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size() + ra_q.size() + rls_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_complete();
        complete = 1'b1;
        @(posedge clk);
        #1;
        complete = 1'b0;
        @(negedge clk);
        chk("layer_done", 64'(layer_done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {(DW / 32){32'hC0DE_0000 + 32'(i * 17)}};
        rstn = 1'b0; cmd_pvld = 1'b0; cmd_pd = '0; complete = 1'b0;
        base_addr = 64'h1000;
        @(negedge clk);
        chk("rst_cmd_prdy", 64'(cmd_prdy), 64'd0);
        chk("rst_pvld", 64'(req_pvld), 64'd0);
        chk("rst_rd_en", 64'(buf_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(buf_rd_addr), 64'd0);
        chk("rst_rls", 64'({rls_vld, rls_cnt}), 64'd0);
        chk("rst_layer_done", 64'(layer_done), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_prdy", 64'(cmd_prdy), 64'd1);
        @(posedge clk);
        #1;

        // 4 beats from entry 3, header at base
        send(4, 3, 0, 64'h1000);
        drain();
        chk("hdr_latency", 64'(hdr_cyc - acc_cyc), 64'd1);
        chk("rls_latency", 64'(rls_cyc - acc_cyc), 64'd6);

        // entry wrap 30,31,0,1; addr advanced by 4*32
        send(4, 30, 1, 64'h1080);
        drain();
        pulse_complete();

        // 3 beats then last 2 beats
        send(3, 0, 0, 64'h1000);
        send(2, 5, 1, 64'h1060);
        drain();
        pulse_complete();

        // 32 beats under random backpressure, header back at base
        rand_prdy = 1;
        send(32, 7, 0, 64'h1000);
        drain();
        rand_prdy = 0;
        chk("max_outstanding_le2", 64'(max_occ <= 2), 64'd1);

        // ack limit: seven last commands
        for (int i = 0; i < 7; i++) send(1, i, 1, (i == 0) ? 64'h1400 : 64'h1000);
        drain();
        @(negedge clk);
        chk("ack_full_cmd_prdy", 64'(cmd_prdy), 64'd0);
        @(posedge clk);
        #1;
        complete = 1'b1;
        @(posedge clk);
        #1;
        complete = 1'b0;
        @(negedge clk);
        chk("layer_done_7", 64'(layer_done), 64'd1);
        chk("ack_free_cmd_prdy", 64'(cmd_prdy), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) pulse_complete();

        // reset in the middle of a 10-beat command
        send(10, 12, 0, 64'h1000);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        base_addr = 64'h2000;
        exp_q.delete();
        ra_q.delete();
        rls_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pvld", 64'(req_pvld), 64'd0);
        chk("midrst_rd_en", 64'(buf_rd_en), 64'd0);
        chk("midrst_rls", 64'(rls_vld), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_midrst_rls", 64'(rls_vld), 64'd0);
        @(posedge clk);
        #1;
        send(2, 0, 0, 64'h2000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
